// File: rtl/digi_ota_array.sv
`default_nettype none
// ============================================================================
//  Module      : digi_ota_array
//  Description : Multi-channel clocked digital OTA. Each channel synchronises
//                an asynchronous vip/vin pair and runs either a hysteretic
//                deadband comparator or a saturating integrator whose value
//                is rendered as a pulse-density (PDM) bitstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module digi_ota_array #(
  parameter int CHANNELS    = 2,
  parameter int ACC_W       = 8,   // must be >= 5 so a full gain step fits
  parameter int SYNC_STAGES = 2,
  parameter int DEADBAND    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [3:0]          gain,
  input  logic [CHANNELS-1:0] vip,
  input  logic [CHANNELS-1:0] vin,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] out_oe,
  output logic [CHANNELS-1:0] sat
);

  localparam logic [1:0] MODE_CMP = 2'd1;
  localparam logic [1:0] MODE_INT = 2'd2;

  localparam logic ST_LO = 1'b0;
  localparam logic ST_HI = 1'b1;

  // One guard bit above the accumulator makes rail overshoot visible.
  localparam int SW = ACC_W + 1;
  localparam logic signed [SW-1:0] ACC_MAX = $signed({2'b00, {(ACC_W-1){1'b1}}});
  localparam logic signed [SW-1:0] ACC_MIN = $signed({2'b11, {(ACC_W-1){1'b0}}});
  localparam logic [3:0] DB4 = 4'(DEADBAND);

  logic [CHANNELS-1:0] sync_p [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_n [SYNC_STAGES];
  logic [CHANNELS-1:0] sp;
  logic [CHANNELS-1:0] sn;

  logic [1:0] mode_q;
  logic [1:0] mode_d;
  logic       en_q;
  logic       en_d;
  logic       active;
  logic       changed;
  logic       run;

  // Input synchroniser chains for both halves of every differential pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_p[i] <= '0;
        sync_n[i] <= '0;
      end
    end else begin
      sync_p[0] <= vip;
      sync_n[0] <= vin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_p[i] <= sync_p[i-1];
        sync_n[i] <= sync_n[i-1];
      end
    end
  end

  assign sp = sync_p[SYNC_STAGES-1];
  assign sn = sync_n[SYNC_STAGES-1];

  // Registered copy of the control inputs plus one cycle of history for change detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 2'd0;
      mode_d <= 2'd0;
      en_q   <= 1'b0;
      en_d   <= 1'b0;
    end else begin
      mode_q <= mode;
      mode_d <= mode_q;
      en_q   <= en;
      en_d   <= en_q;
    end
  end

  // A change cycle flushes every channel so the new mode always starts clean.
  assign active  = en_q & ((mode_q == MODE_CMP) | (mode_q == MODE_INT));
  assign changed = (mode_q != mode_d) | (en_q != en_d);
  assign run     = active & ~changed;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic                    drive_up;
    logic                    drive_dn;
    logic                    state;
    logic                    state_nx;
    logic [3:0]              cnt;
    logic [3:0]              cnt_nx;
    logic [3:0]              cnt_inc;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nx;
    logic signed [SW-1:0]    acc_ext;
    logic signed [SW-1:0]    step;
    logic signed [SW-1:0]    req;
    logic [ACC_W-1:0]        phase;
    logic [ACC_W-1:0]        phase_nx;
    logic [ACC_W:0]          pdm_sum;
    logic                    out_q;
    logic                    oe_q;
    logic                    sat_q;
    logic                    out_nx;
    logic                    oe_nx;
    logic                    sat_nx;

    assign drive_up = sp[ch] & ~sn[ch];
    assign drive_dn = ~sp[ch] & sn[ch];
    assign cnt_inc  = cnt + 4'd1;
    assign acc_ext  = {acc[ACC_W-1], acc};
    assign step     = $signed({{(SW-4){1'b0}}, gain});
    // Offset-binary view of the accumulator drives the PDM phase adder.
    assign pdm_sum  = {1'b0, phase} + {1'b0, ~acc[ACC_W-1], acc[ACC_W-2:0]};

    // Channel state and output registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= ST_LO;
        cnt   <= '0;
        acc   <= '0;
        phase <= '0;
        out_q <= 1'b0;
        oe_q  <= 1'b0;
        sat_q <= 1'b0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        acc   <= acc_nx;
        phase <= phase_nx;
        out_q <= out_nx;
        oe_q  <= oe_nx;
        sat_q <= sat_nx;
      end
    end

    // Next-state logic: comparator FSM/run counter or saturating integrator
    always_comb begin
      state_nx = ST_LO;
      cnt_nx   = '0;
      acc_nx   = '0;
      phase_nx = '0;
      sat_nx   = 1'b0;
      req      = acc_ext;
      if (run) begin
        if (mode_q == MODE_CMP) begin
          state_nx = state;
          cnt_nx   = cnt;
          if (state == ST_LO) begin
            if (drive_up) begin
              if (cnt_inc == DB4) begin
                state_nx = ST_HI;
                cnt_nx   = '0;
              end else begin
                cnt_nx = cnt_inc;
              end
            end else if (drive_dn) begin
              cnt_nx = '0;
            end
          end else begin
            if (drive_dn) begin
              if (cnt_inc == DB4) begin
                state_nx = ST_LO;
                cnt_nx   = '0;
              end else begin
                cnt_nx = cnt_inc;
              end
            end else if (drive_up) begin
              cnt_nx = '0;
            end
          end
        end else begin
          if (drive_up) begin
            req = acc_ext + step;
          end else if (drive_dn) begin
            req = acc_ext - step;
          end
          if (req > ACC_MAX) begin
            acc_nx = ACC_MAX[ACC_W-1:0];
            sat_nx = 1'b1;
          end else if (req < ACC_MIN) begin
            acc_nx = ACC_MIN[ACC_W-1:0];
            sat_nx = 1'b1;
          end else begin
            acc_nx = req[ACC_W-1:0];
          end
          phase_nx = pdm_sum[ACC_W-1:0];
        end
      end
    end

    // Output decode: comparator level or PDM carry, pad enabled only while running
    always_comb begin
      out_nx = 1'b0;
      oe_nx  = run;
      if (run) begin
        if (mode_q == MODE_CMP) begin
          out_nx = (state_nx == ST_HI);
        end else begin
          out_nx = pdm_sum[ACC_W];
        end
      end
    end

    assign out[ch]    = out_q;
    assign out_oe[ch] = oe_q;
    assign sat[ch]    = sat_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_digi_ota_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digi_ota_array
//  Description : Self-checking bench for digi_ota_array with a behavioural
//                per-cycle model plus directed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_digi_ota_array;
  localparam int CH    = 2;
  localparam int ACC_W = 8;
  localparam int SS    = 2;
  localparam int DB    = 3;
  localparam int AMAX  = 127;
  localparam int AMIN  = -128;

  logic          clk  = 1'b0;
  logic          rst  = 1'b0;
  logic          en   = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [3:0]    gain = 4'd0;
  logic [CH-1:0] vip  = '0;
  logic [CH-1:0] vin  = '0;
  logic [CH-1:0] out;
  logic [CH-1:0] out_oe;
  logic [CH-1:0] sat;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  digi_ota_array #(
    .CHANNELS(CH), .ACC_W(ACC_W), .SYNC_STAGES(SS), .DEADBAND(DB)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .gain(gain),
    .vip(vip), .vin(vin), .out(out), .out_oe(out_oe), .sat(sat)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_mode_r, m_mode_p, m_en_r, m_en_p;
  int m_pp [CH][SS];
  int m_pn [CH][SS];
  int m_hi [CH];
  int m_run[CH];
  int m_acc[CH];
  int m_ph [CH];
  int e_out[CH];
  int e_oe [CH];
  int e_sat[CH];

  task automatic model_reset();
    m_mode_r = 0; m_mode_p = 0; m_en_r = 0; m_en_p = 0;
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < SS; k++) begin m_pp[c][k] = 0; m_pn[c][k] = 0; end
      m_hi[c] = 0; m_run[c] = 0; m_acc[c] = 0; m_ph[c] = 0;
      e_out[c] = 0; e_oe[c] = 0; e_sat[c] = 0;
    end
  endtask

  task automatic model_step();
    int d, req, sum, g;
    bit act, chg;
    g   = int'(gain);
    act = (m_en_r == 1) && (m_mode_r == 1 || m_mode_r == 2);
    chg = (m_mode_r != m_mode_p) || (m_en_r != m_en_p);
    for (int c = 0; c < CH; c++) begin
      d = m_pp[c][SS-1] - m_pn[c][SS-1];
      e_sat[c] = 0;
      if (!act || chg) begin
        m_hi[c] = 0; m_run[c] = 0; m_acc[c] = 0; m_ph[c] = 0;
        e_out[c] = 0; e_oe[c] = 0;
      end else if (m_mode_r == 1) begin
        // toward-flip drive counts, opposing drive restarts, tie keeps the count
        if ((m_hi[c] == 0 && d > 0) || (m_hi[c] == 1 && d < 0)) begin
          m_run[c]++;
          if (m_run[c] == DB) begin m_hi[c] = 1 - m_hi[c]; m_run[c] = 0; end
        end else if (d != 0) begin
          m_run[c] = 0;
        end
        e_out[c] = m_hi[c]; e_oe[c] = 1;
      end else begin
        sum      = m_ph[c] + m_acc[c] + 128;
        e_out[c] = (sum >= 256) ? 1 : 0;
        m_ph[c]  = sum % 256;
        req      = m_acc[c] + d * g;
        if (req > AMAX)      begin m_acc[c] = AMAX; e_sat[c] = 1; end
        else if (req < AMIN) begin m_acc[c] = AMIN; e_sat[c] = 1; end
        else                 m_acc[c] = req;
        e_oe[c] = 1;
      end
      for (int k = SS-1; k > 0; k--) begin m_pp[c][k] = m_pp[c][k-1]; m_pn[c][k] = m_pn[c][k-1]; end
      m_pp[c][0] = int'(vip[c]);
      m_pn[c][0] = int'(vin[c]);
    end
    m_mode_p = m_mode_r; m_mode_r = int'(mode);
    m_en_p   = m_en_r;   m_en_r   = int'(en);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- checkers ----------------
  task automatic chk_vec(string nm, logic [CH-1:0] got, logic [CH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_int(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_rng(string nm, int got, int lo, int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", nm, got, lo, hi, $time);
    end
  endtask

  // Model comparison on every falling edge
  always @(negedge clk) begin
    logic [CH-1:0] eo, eoe, es;
    if (chk_on) begin
      for (int c = 0; c < CH; c++) begin
        eo[c] = e_out[c][0]; eoe[c] = e_oe[c][0]; es[c] = e_sat[c][0];
      end
      chk_vec("model_out", out, eo);
      chk_vec("model_oe", out_oe, eoe);
      chk_vec("model_sat", sat, es);
    end
  end

  // ---------------- stimulus ----------------
  int lat, cnt0, cnt1, first_sat, nsat;
  int oe_tr[21];
  int out_tr[21];
  int sat_tr[21];

  initial begin
    // 1: reset with active-looking inputs, then idle with en=0
    vip = '1; vin = '0; mode = 2'd1; en = 1'b0;
    #1 rst = 1'b1;
    #1 chk_on = 1'b1;
    chk_vec("rst_out", out, 2'b00);
    chk_vec("rst_oe", out_oe, 2'b00);
    chk_vec("rst_sat", sat, 2'b00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_vec("idle_out", out, 2'b00);
    chk_vec("idle_oe", out_oe, 2'b00);

    // 2: comparator latency and glitch rejection
    vip = '0; vin = '0; en = 1'b1; mode = 2'd1;
    repeat (8) @(negedge clk);
    chk_vec("cmp_idle_oe", out_oe, 2'b11);
    vip[0] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (out[0] === 1'b1 && lat == 0) lat = k;
    end
    chk_int("cmp_rise_latency", lat, SS + DB);
    @(negedge clk); vip[0] = 1'b0; vin[0] = 1'b1;
    @(negedge clk); @(negedge clk); vip[0] = 1'b1; vin[0] = 1'b0;
    cnt0 = 0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (out[0] !== 1'b1) cnt0++; end
    chk_int("glitch_low_cycles", cnt0, 0);

    // 3: tie hold in HI, then a real falling drive
    vip[0] = 1'b1; vin[0] = 1'b1;
    cnt0 = 0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (out[0] !== 1'b1) cnt0++; end
    chk_int("tie_low_cycles", cnt0, 0);
    vip[0] = 1'b0; vin[0] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (out[0] === 1'b0 && lat == 0) lat = k;
    end
    chk_int("cmp_fall_latency", lat, SS + DB);

    // 4/6: mode switch 1->2 while out=1, then integrator saturation
    @(negedge clk); vip[0] = 1'b1; vin[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk_int("pre_switch_out", int'(out[0]), 1);
    gain = 4'd15; mode = 2'd2;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      oe_tr[k] = int'(out_oe[0]); out_tr[k] = int'(out[0]); sat_tr[k] = int'(sat[0]);
    end
    chk_int("switch_oe_before", oe_tr[1], 1);
    chk_int("switch_oe_gap", oe_tr[2], 0);
    chk_int("switch_out_gap", out_tr[2], 0);
    chk_int("switch_oe_after", oe_tr[3], 1);
    first_sat = 0; nsat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (sat_tr[k] == 1 && first_sat == 0) first_sat = k;
      if (sat_tr[k] == 1) nsat++;
    end
    chk_int("first_sat_edge", first_sat, 11);
    chk_int("sat_pulse_count", nsat, 10);
    @(negedge clk);
    cnt0 = 0;
    for (int k = 0; k < 256; k++) begin @(negedge clk); cnt0 += int'(out[0]); end
    chk_rng("duty_top_rail", cnt0, 254, 256);

    // 6: async reset mid-run clears outputs before any clock edge
    @(negedge clk); #2 rst = 1'b1; #1;
    chk_vec("async_rst_out", out, 2'b00);
    chk_vec("async_rst_oe", out_oe, 2'b00);
    chk_vec("async_rst_sat", sat, 2'b00);
    vip = '0; vin = '0;
    @(negedge clk); rst = 1'b0;

    // 5: mid-value PDM then opposite drives on the two channels
    repeat (10) @(negedge clk);
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk); cnt0 += int'(out[0]); cnt1 += int'(out[1]);
    end
    chk_int("duty_mid_ch0", cnt0, 128);
    chk_int("duty_mid_ch1", cnt1, 128);
    vip = 2'b01; vin = 2'b10;
    repeat (20) @(negedge clk);
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk); cnt0 += int'(out[0]); cnt1 += int'(out[1]);
    end
    chk_rng("duty_diverge_ch0", cnt0, 254, 256);
    chk_int("duty_diverge_ch1", cnt1, 0);

    // Randomised run checked cycle-by-cycle against the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) vip = CH'($urandom);
      if ($urandom_range(0, 3) == 0) vin = CH'($urandom);
      if ($urandom_range(0, 15) == 0) gain = 4'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        r = $urandom_range(0, 9);
        mode = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 6) ? 2'd1 : 2'd2;
      end
      if ($urandom_range(0, 79) == 0) en = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 599) == 0) begin #2 rst = 1'b1; #1 rst = 1'b0; end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
